// File: rtl/fpu_lib.sv
// fpu_lib: shared fp16 types plus the state encoding of the multiplier scheduler.
package fpu_lib;
   typedef logic [15:0] fp16_t;
   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } condCode_t;
   typedef enum logic [1:0] {SCHED_IDLE, SCHED_ISSUE, SCHED_BUSY, SCHED_RESP} mulSchedState_t;
   localparam fp16_t FP16_QNAN = 16'h7E00;
endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: combinational round-robin pick of the first request at or after i_ptr.
module fpu_rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int ID_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);
   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      o_idx = '0;
      o_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
            o_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            o_any = 1'b1;
         end
      end
      o_grant = o_any ? NUM_REQ'(1) << o_idx : '0;
   end
endmodule

// File: rtl/fpu_mul_sched.sv
// fpu_mul_sched: shares one fpuMul16 unit between NUM_REQ requesters, round-robin.
// Define MUL_TIMEOUT_EN to add a BUSY watchdog that answers qNaN with rsp_err set.
module fpu_mul_sched
   import fpu_lib::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W = $clog2(NUM_REQ)
`ifdef MUL_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*16-1:0] req_in1,
   input  logic [NUM_REQ*16-1:0] req_in2,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_data,
   output logic [3:0]           rsp_cc,
   output logic                 rsp_err,
   output logic [15:0]          mul_in1,
   output logic [15:0]          mul_in2,
   output logic                 mul_start,
   output logic                 mul_reset,
   input  logic                 mul_done,
   input  logic [15:0]          mul_out,
   input  logic [3:0]           mul_cc
);
   mulSchedState_t r_state;
   logic [ID_W-1:0] r_ptr, r_id, w_idx;
   logic [NUM_REQ-1:0] w_grant;
   logic w_any, w_timeout;
   fp16_t r_in1, r_in2, r_data;
   condCode_t r_cc;
   logic r_valid, r_start, r_mreset, r_err;

   fpu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req(req_valid),
      .i_ptr(r_ptr),
      .o_grant(w_grant),
      .o_idx(w_idx),
      .o_any(w_any)
   );

   assign req_ready = (reset && r_state == SCHED_IDLE) ? w_grant : '0;

`ifdef MUL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_cnt;
   assign w_timeout = r_state == SCHED_BUSY && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_cnt <= '0;
      else if (r_state == SCHED_ISSUE) r_cnt <= '0;
      else if (r_state == SCHED_BUSY) r_cnt <= r_cnt + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   // The unit parks in MUL_DONE, so it is held in reset whenever no operation is in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= SCHED_IDLE;
         r_ptr    <= '0;
         r_id     <= '0;
         r_in1    <= '0;
         r_in2    <= '0;
         r_data   <= '0;
         r_cc     <= '0;
         r_err    <= 1'b0;
         r_valid  <= 1'b0;
         r_start  <= 1'b0;
         r_mreset <= 1'b1;
      end else begin
         case (r_state)
            SCHED_IDLE: if (w_any) begin
               r_state  <= SCHED_ISSUE;
               r_in1    <= req_in1[16*w_idx +: 16];
               r_in2    <= req_in2[16*w_idx +: 16];
               r_id     <= w_idx;
               r_ptr    <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
               r_start  <= 1'b1;
               r_mreset <= 1'b0;
            end
            SCHED_ISSUE: begin
               r_state <= SCHED_BUSY;
               r_start <= 1'b0;
            end
            SCHED_BUSY: if (mul_done || w_timeout) begin
               r_state  <= SCHED_RESP;
               r_valid  <= 1'b1;
               r_mreset <= 1'b1;
               r_data   <= mul_done ? mul_out : FP16_QNAN;
               r_cc     <= mul_done ? condCode_t'(mul_cc) : '0;
               r_err    <= !mul_done;
            end
            SCHED_RESP: if (rsp_ready) begin
               r_state <= SCHED_IDLE;
               r_valid <= 1'b0;
            end
            default: r_state <= SCHED_IDLE;
         endcase
      end
   end

   assign rsp_valid = r_valid;
   assign rsp_id    = r_id;
   assign rsp_data  = r_data;
   assign rsp_cc    = r_cc;
   assign rsp_err   = r_err;
   assign mul_in1   = r_in1;
   assign mul_in2   = r_in2;
   assign mul_start = r_start;
   assign mul_reset = r_mreset;
endmodule

// File: doc/fpu_mul_sched.md
Name: fpu_mul_sched

Overview:
Round-robin scheduler that shares one fpuMul16 coprocessor between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready.
- Latches the operands and holds them stable on the unit inputs.
- Pulses start, waits for done, captures the result and condition codes.
- Returns the result tagged with the requester index over a valid/ready response channel.
- Holds the unit in reset between operations, because the unit's FSM parks in MUL_DONE.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, $clog2(NUM_REQ), width of the requester index.
TIMEOUT_CYCLES, 64, watchdog limit in BUSY; used only with MUL_TIMEOUT_EN.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_in1  in  NUM_REQ*16  packed fp16_t operand A; requester i occupies bits [16i+15:16i]
req_in2  in  NUM_REQ*16  packed fp16_t operand B
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester being answered
rsp_data  out  16  fp16_t product
rsp_cc  out  4  condCode_t {Z,C,N,V} from the unit
rsp_err  out  1  timeout flag
mul_in1  out  16  unit operand A (registered)
mul_in2  out  16  unit operand B (registered)
mul_start  out  1  unit start
mul_reset  out  1  unit active-high reset
mul_done  in  1  unit done
mul_out  in  16  unit result
mul_cc  in  4  unit condition codes

Behaviour:
- Reset (reset low, async) puts the block in this state:
  - state IDLE; rr pointer 0.
  - req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_cc 0, rsp_err 0.
  - mul_in1/mul_in2 0, mul_start 0, mul_reset 1.
  - Reset mid-operation aborts the operation; the response is lost.
- States and transitions:
  - IDLE -> ISSUE: any req_valid set.
  - ISSUE -> BUSY: always, after 1 cycle.
  - BUSY -> RESP: on mul_done (or on timeout).
  - RESP -> IDLE: on rsp_valid && rsp_ready.
- IDLE:
  - mul_reset=1.
  - Round-robin arbiter picks the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready is driven combinationally, one-hot to the winner; all zeros if no request.
  - On the handshake edge: latch that requester's operands into mul_in1/in2, latch the winner into rsp_id, set pointer = winner+1 mod NUM_REQ.
- ISSUE: mul_reset=0, mul_start=1 for exactly one cycle.
- BUSY:
  - mul_reset=0, mul_start=0; operands held.
  - On the first cycle mul_done=1: capture mul_out -> rsp_data and mul_cc -> rsp_cc, set rsp_err=0.
- RESP:
  - rsp_valid=1, mul_reset=1.
  - rsp_id/rsp_data/rsp_cc/rsp_err held stable until the handshake; rsp_valid is not dropped without rsp_ready.
- Latency: request handshake at edge T -> ISSUE in cycle T+1 -> earliest rsp_valid is 1 cycle after the cycle mul_done is first seen.
- Throughput: at most one operation in flight. req_ready is never asserted outside IDLE.
- Requester obligations:
  - A granted requester sees req_ready for one cycle only.
  - Non-granted requesters keep req_valid asserted and wait.
- Requester i asserting and then dropping req_valid before a grant is legal; it is simply not served.
- mul_done asserted outside BUSY is ignored.
- Back-to-back operation: rsp handshake in cycle N -> IDLE in N+1 -> the next grant may occur in N+1.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,...,NUM_REQ-1,0,...

Optional Feature:
MUL_TIMEOUT_EN
- Defined:
  - A counter clears on ISSUE and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with mul_done still 0, the block goes to RESP with rsp_data=16'h7E00 (qNaN), rsp_cc=4'b0000, rsp_err=1.
  - mul_done arriving in the same cycle as the timeout wins; rsp_err=0.
- Undefined: no counter is built; rsp_err is tied 0; BUSY waits indefinitely.

Decomposition:
- fpu_lib gains typedef enum mulSchedState_t {SCHED_IDLE, SCHED_ISSUE, SCHED_BUSY, SCHED_RESP}.
- The block reuses the existing fp16_t and condCode_t from fpu_lib.
- One sub-module: fpu_rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational; the pointer register lives in fpu_mul_sched.

Test Plan:
1. Single op: requester 2 sends 0x3E00 x 0x4000 (1.5x2.0) -> one rsp with rsp_id=2, rsp_data=0x4200, rsp_cc Z=0 N=0; mul_start high exactly 1 cycle.
2. Fairness: all 4 requesters valid continuously for 8 ops -> rsp_id sequence 0,1,2,3,0,1,2,3; no requester starved.
3. Response backpressure: rsp_ready held low 10 cycles -> rsp_valid/rsp_data/rsp_id stable; mul_reset=1; no req_ready; accepts the next request the cycle after the handshake.
4. Sign/zero: 0xBC00 x 0x3C00 -> rsp_data=0xBC00 with N=1. 0x0000 x 0x4500 -> rsp_data=0x0000 with Z=1.
5. Reset mid-BUSY: pull reset low during BUSY -> all outputs at reset values immediately; pointer 0; a subsequent request from requester 0 is granted first.
6. MUL_TIMEOUT_EN: bench model never raises mul_done -> rsp after TIMEOUT_CYCLES BUSY cycles with rsp_data=0x7E00, rsp_err=1. Second case: done raised on the final cycle -> rsp_err=0.
